// File: rtl/ctrl_seq_mc.sv
// Multi-channel FIR sequencer: fetches one pointer instruction per pass and walks every
// channel's circular sample window against the coefficient table, driving RAM/MAC/regfile strobes.
module ctrl_seq_mc #(
  parameter int REGFILE_ADDR_WIDTH = 2,
  parameter int DATA_ADDR_WIDTH    = 4,
  parameter int CH_NUM             = 2,
  parameter int CH_W               = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  en,
  input  logic                                                  prog,
  input  logic                                                  iw_valid,
  input  logic [DATA_ADDR_WIDTH-1:0]                            load_coef_addr,
  input  logic [2+2*REGFILE_ADDR_WIDTH+4*DATA_ADDR_WIDTH-1:0]   instr_word,
  output logic                                                  ptr_req,
  output logic                                                  mac_init,
  output logic                                                  en_calc,
  output logic                                                  en_ram_pa,
  output logic                                                  en_ram_pb,
  output logic                                                  wr_ram_pa,
  output logic                                                  wr_ram_pb,
  output logic                                                  regf_rd,
  output logic                                                  regf_wr,
  output logic                                                  regf_en,
  output logic                                                  new_in,
  output logic                                                  new_out,
  output logic [CH_W+DATA_ADDR_WIDTH-1:0]                       data_addr,
  output logic [DATA_ADDR_WIDTH-1:0]                            coef_addr,
  output logic [REGFILE_ADDR_WIDTH-1:0]                         ares,
  output logic [REGFILE_ADDR_WIDTH-1:0]                         aerr,
  output logic [CH_W-1:0]                                       ch_idx
);

  // state     | meaning
  // IDLE      | parked; prog=1 streams coefficient writes to coef RAM
  // PTR_REQ   | requesting next instruction, waits for iw_valid
  // CALC_INIT | clear MAC, first tap of current channel, read error reg
  // CALC      | remaining taps, circular sample pointer walk
  // LOAD      | write result; next channel or next instruction

  localparam int DAW  = DATA_ADDR_WIDTH;
  localparam int RAW  = REGFILE_ADDR_WIDTH;
  localparam int IW_W = 2 + 2*RAW + 4*DAW;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PTR_REQ,
    S_CALC_INIT,
    S_CALC,
    S_LOAD
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IW_W-1:0]   instr_q;
  logic [DAW:0]      tap_cnt;
  logic [DAW-1:0]    samp_ptr;
  logic [DAW-1:0]    coef_cnt;

  logic [DAW-1:0]    coef_ptr;
  logic [DAW-1:0]    hptr;
  logic [DAW-1:0]    lptr;
  logic [DAW-1:0]    bptr;
  logic [RAW-1:0]    error_reg;
  logic [RAW-1:0]    result_reg;
  logic              startups_f;
  logic              lstg_f;

  logic [DAW:0]      taps_m1;
  logic              last_ch;
  logic              abort;
  logic [DAW-1:0]    samp_src;
  logic [DAW-1:0]    samp_step;

  assign coef_ptr   = instr_q[DAW-1:0];
  assign hptr       = instr_q[2*DAW-1:DAW];
  assign lptr       = instr_q[3*DAW-1:2*DAW];
  assign bptr       = instr_q[4*DAW-1:3*DAW];
  assign error_reg  = instr_q[4*DAW+RAW-1:4*DAW];
  assign result_reg = instr_q[4*DAW+2*RAW-1:4*DAW+RAW];
  assign startups_f = instr_q[4*DAW+2*RAW];
  assign lstg_f     = instr_q[4*DAW+2*RAW+1];

  assign taps_m1 = {1'b0, hptr} - {1'b0, bptr};
  assign last_ch = (ch_idx == CH_LAST);
  assign abort   = en && prog && (state != S_IDLE);

  // Sample window walks downward and wraps from the base back to the head.
  assign samp_src  = (state == S_CALC_INIT) ? lptr : samp_ptr;
  assign samp_step = (samp_src == bptr) ? hptr : samp_src - DAW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      if (prog && (state != S_IDLE)) begin
        state_nxt = S_IDLE;
      end else begin
        case (state)
          S_IDLE:      if (!prog) state_nxt = S_PTR_REQ;
          S_PTR_REQ:   if (iw_valid) state_nxt = S_CALC_INIT;
          S_CALC_INIT: state_nxt = (taps_m1 == '0) ? S_LOAD : S_CALC;
          S_CALC:      if (tap_cnt == (DAW+1)'(1)) state_nxt = S_LOAD;
          S_LOAD:      state_nxt = last_ch ? S_PTR_REQ : S_CALC_INIT;
          default:     state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      ch_idx   <= '0;
      tap_cnt  <= '0;
      samp_ptr <= '0;
      coef_cnt <= '0;
    end else if (en) begin
      if (abort) begin
        ch_idx <= '0;
      end else begin
        case (state)
          S_PTR_REQ: begin
            if (iw_valid) begin
              instr_q <= instr_word;
              ch_idx  <= '0;
            end
          end
          S_CALC_INIT: begin
            samp_ptr <= samp_step;
            coef_cnt <= coef_ptr + DAW'(1);
            tap_cnt  <= taps_m1;
          end
          S_CALC: begin
            samp_ptr <= samp_step;
            coef_cnt <= coef_cnt + DAW'(1);
            tap_cnt  <= tap_cnt - (DAW+1)'(1);
          end
          S_LOAD: begin
            ch_idx <= last_ch ? '0 : ch_idx + CH_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Strobes are gated by en; addresses follow the held registers so a stall keeps them stable.
  always_comb begin
    ptr_req   = 1'b0;
    mac_init  = 1'b0;
    en_calc   = 1'b0;
    en_ram_pa = 1'b0;
    en_ram_pb = 1'b0;
    wr_ram_pb = 1'b0;
    regf_rd   = 1'b0;
    regf_wr   = 1'b0;
    regf_en   = 1'b0;
    new_in    = 1'b0;
    new_out   = 1'b0;
    data_addr = {ch_idx, samp_ptr};
    coef_addr = coef_cnt;
    ares      = '0;
    aerr      = '0;
    case (state)
      S_IDLE: begin
        if (en && prog) begin
          en_ram_pb = 1'b1;
          wr_ram_pb = 1'b1;
          coef_addr = load_coef_addr;
        end
      end
      S_PTR_REQ: begin
        ptr_req = en;
      end
      S_CALC_INIT: begin
        mac_init  = en;
        en_calc   = en;
        en_ram_pa = en;
        en_ram_pb = en;
        regf_rd   = en;
        regf_en   = en;
        data_addr = {ch_idx, lptr};
        coef_addr = coef_ptr;
        aerr      = error_reg;
      end
      S_CALC: begin
        en_calc   = en;
        en_ram_pa = en;
        en_ram_pb = en;
      end
      S_LOAD: begin
        regf_wr = en;
        regf_en = en;
        ares    = result_reg;
        aerr    = error_reg;
        if (last_ch && !prog) begin
          new_out = en && lstg_f;
          new_in  = en && !startups_f;
        end
      end
      default: ;
    endcase
  end

  // Sample RAM writes belong to the input stage.
  assign wr_ram_pa = 1'b0;

endmodule

// File: tb/tb_ctrl_seq_mc.sv
// Self-checking bench for ctrl_seq_mc: directed scenarios plus random instructions compared
// against a per-cycle expectation list built from tap count / circular window arithmetic.
module tb_ctrl_seq_mc;
  localparam int RAW    = 2;
  localparam int DAW    = 4;
  localparam int CH_NUM = 2;
  localparam int CH_W   = 1;
  localparam int IW_W   = 2 + 2*RAW + 4*DAW;

  // strobe vector order: ptr_req mac_init en_calc en_ram_pa en_ram_pb wr_ram_pa wr_ram_pb
  //                      regf_rd regf_wr regf_en new_in new_out
  localparam logic [11:0] S_NONE = 12'h000;
  localparam logic [11:0] S_PTR  = 12'h800;
  localparam logic [11:0] S_INIT = 12'h794;
  localparam logic [11:0] S_CALC = 12'h380;
  localparam logic [11:0] S_LOAD = 12'h00C;
  localparam logic [11:0] S_PROG = 12'h0A0;

  localparam logic [25:0] M_STB = 26'h3FFC000;
  localparam logic [25:0] M_CH  = 26'h0002000;
  localparam logic [25:0] M_DA  = 26'h0001F00;
  localparam logic [25:0] M_CA  = 26'h00000F0;
  localparam logic [25:0] M_AR  = 26'h000000C;
  localparam logic [25:0] M_AE  = 26'h0000003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, en, prog, iw_valid;
  logic [DAW-1:0]        load_coef_addr;
  logic [IW_W-1:0]       instr_word;
  logic                  ptr_req, mac_init, en_calc, en_ram_pa, en_ram_pb, wr_ram_pa, wr_ram_pb;
  logic                  regf_rd, regf_wr, regf_en, new_in, new_out;
  logic [CH_W+DAW-1:0]   data_addr;
  logic [DAW-1:0]        coef_addr;
  logic [RAW-1:0]        ares, aerr;
  logic [CH_W-1:0]       ch_idx;

  ctrl_seq_mc #(
    .REGFILE_ADDR_WIDTH(RAW), .DATA_ADDR_WIDTH(DAW), .CH_NUM(CH_NUM), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .prog(prog), .iw_valid(iw_valid),
    .load_coef_addr(load_coef_addr), .instr_word(instr_word),
    .ptr_req(ptr_req), .mac_init(mac_init), .en_calc(en_calc),
    .en_ram_pa(en_ram_pa), .en_ram_pb(en_ram_pb), .wr_ram_pa(wr_ram_pa), .wr_ram_pb(wr_ram_pb),
    .regf_rd(regf_rd), .regf_wr(regf_wr), .regf_en(regf_en),
    .new_in(new_in), .new_out(new_out),
    .data_addr(data_addr), .coef_addr(coef_addr), .ares(ares), .aerr(aerr), .ch_idx(ch_idx)
  );

  wire [11:0] stb = {ptr_req, mac_init, en_calc, en_ram_pa, en_ram_pb, wr_ram_pa, wr_ram_pb,
                     regf_rd, regf_wr, regf_en, new_in, new_out};
  wire [25:0] sig = {stb, ch_idx, data_addr, coef_addr, ares, aerr};

  int tests_run    = 0;
  int tests_failed = 0;
  int cnt_mac_init, cnt_regf_wr, cnt_new_in, cnt_new_out;
  logic [25:0] exp_q[$];
  logic [25:0] msk_q[$];

  function automatic logic [25:0] mk(logic [11:0] s, logic ch, logic [4:0] da, logic [3:0] ca,
                                     logic [1:0] ar, logic [1:0] ae);
    return {s, ch, da, ca, ar, ae};
  endfunction

  function automatic logic [IW_W-1:0] pack_iw(logic lstg, logic st, logic [1:0] res, logic [1:0] err,
                                              logic [3:0] b, logic [3:0] l, logic [3:0] h, logic [3:0] c);
    return {lstg, st, res, err, b, l, h, c};
  endfunction

  // Expected cycles from the first CALC_INIT through the next instruction request.
  function automatic void model(logic [IW_W-1:0] iw);
    int c, h, l, b, n, p;
    logic [1:0] err, res;
    logic st, lstg, cb;
    logic [11:0] s;
    c = int'(iw[3:0]); h = int'(iw[7:4]); l = int'(iw[11:8]); b = int'(iw[15:12]);
    err = iw[17:16]; res = iw[19:18]; st = iw[20]; lstg = iw[21];
    n = h - b + 1;
    exp_q.delete();
    msk_q.delete();
    for (int ch = 0; ch < CH_NUM; ch++) begin
      cb = 1'(ch);
      exp_q.push_back(mk(S_INIT, cb, {cb, 4'(l)}, 4'(c), 2'b00, err));
      msk_q.push_back(M_STB | M_CH | M_DA | M_CA | M_AE);
      for (int k = 1; k < n; k++) begin
        p = b + (((l - b - k) % n) + n) % n;
        exp_q.push_back(mk(S_CALC, cb, {cb, 4'(p)}, 4'((c + k) % 16), 2'b00, 2'b00));
        msk_q.push_back(M_STB | M_CH | M_DA | M_CA);
      end
      s = S_LOAD;
      if (ch == CH_NUM - 1) s = s | {10'b0, ~st, lstg};
      exp_q.push_back(mk(s, cb, 5'd0, 4'd0, res, err));
      msk_q.push_back(M_STB | M_CH | M_AR | M_AE);
    end
    exp_q.push_back(mk(S_PTR, 1'b0, 5'd0, 4'd0, 2'b00, 2'b00));
    msk_q.push_back(M_STB);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in a PTR_REQ cycle, ends in the following PTR_REQ cycle.
  task automatic run_instr(input string name, input logic [IW_W-1:0] iw, input int valid_delay,
                           input int freeze_at);
    logic [25:0] e, m;
    model(iw);
    cnt_mac_init = 0; cnt_regf_wr = 0; cnt_new_in = 0; cnt_new_out = 0;
    for (int d = 0; d < valid_delay; d++) begin
      tests_run++;
      if (stb !== S_PTR) begin
        tests_failed++;
        $display("FAIL %s handshake_wait[%0d]: strobes %h want %h", name, d, stb, S_PTR);
      end
      tick();
    end
    tests_run++;
    if (stb !== S_PTR) begin
      tests_failed++;
      $display("FAIL %s ptr_req_ready: strobes %h want %h", name, stb, S_PTR);
    end
    instr_word = iw;
    iw_valid = 1'b1;
    tick();
    iw_valid = 1'b0;
    instr_word = IW_W'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      e = exp_q[i];
      m = msk_q[i];
      tests_run++;
      if ((sig & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL %s cycle[%0d]: got %h want %h (mask %h)", name, i, sig & m, e & m, m);
      end
      cnt_mac_init += int'(mac_init);
      cnt_regf_wr  += int'(regf_wr);
      cnt_new_in   += int'(new_in);
      cnt_new_out  += int'(new_out);
      if (i == freeze_at) begin
        en = 1'b0;
        for (int f = 0; f < 2; f++) begin
          tick();
          tests_run++;
          if ((sig & m) !== (e & m & ~M_STB)) begin
            tests_failed++;
            $display("FAIL %s frozen[%0d.%0d]: got %h want %h", name, i, f, sig & m, e & m & ~M_STB);
          end
        end
        en = 1'b1;
        #1;
        tests_run++;
        if ((sig & m) !== (e & m)) begin
          tests_failed++;
          $display("FAIL %s resume[%0d]: got %h want %h", name, i, sig & m, e & m);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; prog = 1'b0; iw_valid = 1'b1;
    load_coef_addr = '0; instr_word = IW_W'($urandom);
    for (int r = 0; r < 2; r++) begin
      tick();
      tests_run++;
      if (sig !== 26'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: got %h want %h", r, sig, 26'h0);
      end
    end
    rst = 1'b0;
    iw_valid = 1'b0;
    tick();
    tests_run++;
    if (sig !== mk(S_PTR, 1'b0, 5'd0, 4'd0, 2'b00, 2'b00)) begin
      tests_failed++;
      $display("FAIL reset_release: got %h want %h", sig, mk(S_PTR, 1'b0, 5'd0, 4'd0, 2'b00, 2'b00));
    end
  endtask

  task automatic test_basic_pass();
    run_instr("basic", pack_iw(1'b1, 1'b0, 2'd2, 2'd1, 4'd0, 4'd1, 4'd3, 4'd8), 0, -1);
    tests_run++;
    if (exp_q.size() != 11) begin
      tests_failed++;
      $display("FAIL basic_cycle_count: got %0d want 11", exp_q.size());
    end
  endtask

  task automatic test_single_tap();
    run_instr("single_tap", pack_iw(1'b0, 1'b1, 2'd1, 2'd2, 4'd5, 4'd5, 4'd5, 4'd3), 0, -1);
    tests_run++;
    if (cnt_mac_init != CH_NUM || cnt_regf_wr != CH_NUM) begin
      tests_failed++;
      $display("FAIL single_tap_pulses: mac_init %0d regf_wr %0d want %0d each",
               cnt_mac_init, cnt_regf_wr, CH_NUM);
    end
  endtask

  task automatic test_flags();
    run_instr("flags_11", pack_iw(1'b1, 1'b1, 2'd3, 2'd0, 4'd4, 4'd6, 4'd7, 4'd14), 0, -1);
    tests_run++;
    if (cnt_new_out != 1 || cnt_new_in != 0) begin
      tests_failed++;
      $display("FAIL flags_11_pulses: new_out %0d new_in %0d want 1 0", cnt_new_out, cnt_new_in);
    end
    run_instr("flags_00", pack_iw(1'b0, 1'b0, 2'd0, 2'd3, 4'd9, 4'd9, 4'd10, 4'd1), 0, -1);
    tests_run++;
    if (cnt_new_out != 0 || cnt_new_in != 1) begin
      tests_failed++;
      $display("FAIL flags_00_pulses: new_out %0d new_in %0d want 0 1", cnt_new_out, cnt_new_in);
    end
  endtask

  task automatic test_handshake_freeze();
    run_instr("freeze", pack_iw(1'b1, 1'b0, 2'd1, 2'd2, 4'd2, 4'd4, 4'd6, 4'd13), 3, 2);
  endtask

  task automatic test_prog();
    logic [IW_W-1:0] iw;
    logic [3:0] lca;
    iw = pack_iw(1'b1, 1'b0, 2'd2, 2'd2, 4'd0, 4'd3, 4'd7, 4'd0);
    model(iw);
    instr_word = iw;
    iw_valid = 1'b1;
    tick();
    iw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      tests_run++;
      if ((sig & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        tests_failed++;
        $display("FAIL prog_pre[%0d]: got %h want %h", i, sig & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    prog = 1'b1;
    load_coef_addr = 4'd7;
    tick();
    for (int r = 0; r < 3; r++) begin
      if (r == 1) begin
        lca = 4'($urandom_range(15, 0));
        load_coef_addr = lca;
        #1;
      end else if (r == 2) begin
        tick();
      end
      tests_run++;
      if ((sig & (M_STB | M_CA | M_CH)) !== mk(S_PROG, 1'b0, 5'd0, load_coef_addr, 2'b00, 2'b00)) begin
        tests_failed++;
        $display("FAIL prog_load[%0d]: got %h want %h", r, sig & (M_STB | M_CA | M_CH),
                 mk(S_PROG, 1'b0, 5'd0, load_coef_addr, 2'b00, 2'b00));
      end
    end
    prog = 1'b0;
    #1;
    tests_run++;
    if (stb !== S_NONE) begin
      tests_failed++;
      $display("FAIL prog_release_idle: strobes %h want %h", stb, S_NONE);
    end
    tick();
    tests_run++;
    if (stb !== S_PTR) begin
      tests_failed++;
      $display("FAIL prog_restart: strobes %h want %h", stb, S_PTR);
    end
  endtask

  task automatic test_random();
    int b, h, l, fz;
    logic [IW_W-1:0] iw;
    for (int t = 0; t < 25; t++) begin
      b = $urandom_range(15, 0);
      h = $urandom_range(15, b);
      l = $urandom_range(h, b);
      iw = pack_iw(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                   4'(b), 4'(l), 4'(h), 4'($urandom));
      fz = ($urandom_range(1, 0) == 1) ? int'($urandom_range(5, 0)) : -1;
      run_instr("random", iw, $urandom_range(2, 0), fz);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_pass();
    test_single_tap();
    test_flags();
    test_handshake_freeze();
    test_prog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
